pc_unit_ras: RTL and testbench

//  Parametrised SAYEH program-counter unit: successor to the single-load PC register.

---
 rtl/pc_unit_ras_if.sv | 31 +++
 rtl/pc_unit_ras.sv | 111 +++++++++++
 tb/tb_pc_unit_ras.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_ras_if.sv
// Controller-to-PC-unit bus: mode/enable/targets in, PC and stack status out.
interface pc_unit_ras_if #(
  parameter int WIDTH = 16,
  parameter int OFF_W = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             enable;
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_addr;
  logic [OFF_W-1:0] offset;
  logic [WIDTH-1:0] pc_out;
  logic [CNT_W-1:0] ras_count;
  logic             ras_full;
  logic             ras_empty;
  logic             ras_ovf;
  logic             ras_unf;

  // Controller side drives the operation and observes the PC.
  modport master (
    output enable, mode, load_addr, offset,
    input  pc_out, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
  );

  // PC unit side.
  modport slave (
    input  enable, mode, load_addr, offset,
    output pc_out, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_unit_ras.sv
// SAYEH program-counter unit with increment, jump, relative branch, call and
// return. Calls push their return address onto a small circular return-address
// stack; overflow overwrites the oldest entry, underflow falls through.
// All state changes on the falling clock edge.
module pc_unit_ras #(
  parameter int WIDTH     = 16,
  parameter int OFF_W     = 8,
  parameter int DEPTH     = 4,
  parameter int INC_STEP  = 1,
  parameter int RESET_VEC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_unit_ras_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_INC   = 3'b001,
    M_JUMP  = 3'b010,
    M_REL   = 3'b011,
    M_CALL  = 3'b100,
    M_RET   = 3'b101,
    M_SOFT  = 3'b110,
    M_RSVD  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_rel;
  logic [WIDTH-1:0] tos;
  logic [PTR_W-1:0] wp_q;
  logic [PTR_W-1:0] wp_dec;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             unf_q;
  logic             full;
  logic             empty;
  logic             do_push;
  mode_e            op;
  logic [WIDTH-1:0] mem [DEPTH];

  assign op      = mode_e'(bus.mode);
  assign pc_inc  = pc_q + WIDTH'(INC_STEP);
  // Branch base is the current PC; the offset is sign-extended to full width.
  assign pc_rel  = pc_q + WIDTH'($signed(bus.offset));
  assign wp_dec  = wp_q - PTR_W'(1);
  assign tos     = mem[wp_dec];
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = bus.enable && (op == M_CALL);

  // Stack storage: push writes the return address at the write pointer.
  // NOTE: the stack array carries no reset; its contents are meaningless while
  // ras_count is 0, so resetting it would only add reset fan-out.
  always_ff @(negedge clk) begin
    if (do_push && rst_n) mem[wp_q] <= pc_inc;
  end

  // PC, stack pointer, occupancy and sticky flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= WIDTH'(RESET_VEC);
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.enable) begin
      unique case (op)
        M_INC:  pc_q <= pc_inc;
        M_JUMP: pc_q <= bus.load_addr;
        M_REL:  pc_q <= pc_rel;
        M_CALL: begin
          pc_q <= bus.load_addr;
          wp_q <= wp_q + PTR_W'(1);
          if (full) ovf_q <= 1'b1;
          else      cnt_q <= cnt_q + CNT_W'(1);
        end
        M_RET: begin
          if (empty) begin
            pc_q  <= pc_inc;
            unf_q <= 1'b1;
          end else begin
            pc_q  <= tos;
            wp_q  <= wp_dec;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        M_SOFT: begin
          pc_q  <= WIDTH'(RESET_VEC);
          wp_q  <= '0;
          cnt_q <= '0;
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
        end
        default: ;  // HOLD and reserved
      endcase
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.ras_count = cnt_q;
  assign bus.ras_full  = full;
  assign bus.ras_empty = empty;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed scenarios then randomized operations, all
// compared against a queue-based reference model of the PC and return stack.
module tb_pc_unit_ras;
  localparam int WIDTH = 16;
  localparam int OFF_W = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pc_unit_ras_if #(.WIDTH(WIDTH), .OFF_W(OFF_W), .DEPTH(DEPTH)) bus ();

  pc_unit_ras #(
    .WIDTH(WIDTH), .OFF_W(OFF_W), .DEPTH(DEPTH), .INC_STEP(1), .RESET_VEC(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: PC value, stack of return addresses (newest at back).
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  bit          m_ovf;
  bit          m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_apply(input logic en, input logic [2:0] md,
                             input logic [15:0] la, input logic [7:0] off);
    logic [15:0] sx;
    if (!en) return;
    sx = {{8{off[7]}}, off};
    case (md)
      3'd1: m_pc = m_pc + 16'd1;
      3'd2: m_pc = la;
      3'd3: m_pc = m_pc + sx;
      3'd4: begin
        if (m_stk.size() == DEPTH) begin
          m_ovf = 1'b1;
          void'(m_stk.pop_front());
        end
        m_stk.push_back(m_pc + 16'd1);
        m_pc = la;
      end
      3'd5: begin
        if (m_stk.size() == 0) begin
          m_unf = 1'b1;
          m_pc  = m_pc + 16'd1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end
      3'd6: model_reset();
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},    32'(bus.pc_out),    32'(m_pc));
    check({tag, ".cnt"},   32'(bus.ras_count), 32'(m_stk.size()));
    check({tag, ".full"},  32'(bus.ras_full),  32'(m_stk.size() == DEPTH));
    check({tag, ".empty"}, 32'(bus.ras_empty), 32'(m_stk.size() == 0));
    check({tag, ".ovf"},   32'(bus.ras_ovf),   32'(m_ovf));
    check({tag, ".unf"},   32'(bus.ras_unf),   32'(m_unf));
  endtask

  // Drive one operation after a rising edge, let the falling edge act, then
  // sample 1 time unit later and compare with the model.
  task automatic step(input string tag, input logic en, input logic [2:0] md,
                      input logic [15:0] la, input logic [7:0] off);
    @(posedge clk); #1;
    bus.enable    = en;
    bus.mode      = md;
    bus.load_addr = la;
    bus.offset    = off;
    @(negedge clk); #1;
    model_apply(en, md, la, off);
    check_state(tag);
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.mode      = 3'd0;
    bus.load_addr = '0;
    bus.offset    = '0;
    model_reset();

    // T1: reset then three increments
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_state("t1_reset");
    for (int i = 1; i <= 3; i++) begin
      step("t1_inc", 1'b1, 3'd1, 16'h0, 8'h0);
      check("t1_pc_const", 32'(bus.pc_out), 32'(i));
    end

    // T2: wrap and negative relative branch
    step("t2_jump", 1'b1, 3'd2, 16'hFFFE, 8'h0);
    step("t2_inc1", 1'b1, 3'd1, 16'h0, 8'h0);
    check("t2_ffff", 32'(bus.pc_out), 32'h0000_FFFF);
    step("t2_inc2", 1'b1, 3'd1, 16'h0, 8'h0);
    check("t2_wrap", 32'(bus.pc_out), 32'h0000_0000);
    step("t2_rel", 1'b1, 3'd3, 16'h0, 8'hFC);
    check("t2_rel_const", 32'(bus.pc_out), 32'h0000_FFFC);

    // T3: nested calls and returns
    step("t3_jump", 1'b1, 3'd2, 16'h0010, 8'h0);
    step("t3_call1", 1'b1, 3'd4, 16'h0100, 8'h0);
    step("t3_call2", 1'b1, 3'd4, 16'h0200, 8'h0);
    step("t3_ret1", 1'b1, 3'd5, 16'h0, 8'h0);
    check("t3_ret1_const", 32'(bus.pc_out), 32'h0101);
    step("t3_ret2", 1'b1, 3'd5, 16'h0, 8'h0);
    check("t3_ret2_const", 32'(bus.pc_out), 32'h0011);
    check("t3_cnt0", 32'(bus.ras_count), 32'd0);

    // T4: overflow; five calls from distinct PCs, four returns
    for (int i = 0; i < 5; i++) begin
      step("t4_jump", 1'b1, 3'd2, 16'h1000 + 16'(i * 16), 8'h0);
      step("t4_call", 1'b1, 3'd4, 16'h8000, 8'h0);
    end
    check("t4_ovf", 32'(bus.ras_ovf), 32'd1);
    check("t4_cnt", 32'(bus.ras_count), 32'd4);
    for (int k = 4; k >= 1; k--) begin
      step("t4_ret", 1'b1, 3'd5, 16'h0, 8'h0);
      check("t4_ret_const", 32'(bus.pc_out), 32'(16'h1000 + 16'(k * 16) + 16'd1));
    end

    // T5: underflow then soft reset
    step("t5_jump", 1'b1, 3'd2, 16'h0040, 8'h0);
    step("t5_ret", 1'b1, 3'd5, 16'h0, 8'h0);
    check("t5_pc_const", 32'(bus.pc_out), 32'h0041);
    check("t5_unf", 32'(bus.ras_unf), 32'd1);
    step("t5_soft", 1'b1, 3'd6, 16'h0, 8'h0);
    check("t5_unf_clr", 32'(bus.ras_unf), 32'd0);

    // T6: enable low holds everything; async reset acts between edges
    step("t6_jump", 1'b1, 3'd2, 16'h0333, 8'h0);
    step("t6_hold", 1'b0, 3'd4, 16'h0777, 8'h0);
    check("t6_hold_pc", 32'(bus.pc_out), 32'h0333);
    @(posedge clk); #2;
    bus.enable = 1'b1;
    bus.mode   = 3'd4;
    bus.load_addr = 16'h0555;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_pc", 32'(bus.pc_out), 32'h0);
    @(negedge clk); #1;
    check_state("t6_in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.enable = 1'b0;

    // Randomized operations
    for (int n = 0; n < 600; n++) begin
      logic       en;
      logic [2:0] md;
      en = ($urandom_range(0, 7) != 0);
      md = 3'($urandom_range(0, 7));
      if (md == 3'd6 && $urandom_range(0, 3) != 0) md = 3'd4;
      step("rnd", en, md, 16'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
